timer_seq_ctrl: RTL
===================

// Module: timer_seq_ctrl
// PURPOSE
// - Initiator side of the single-shot timer interface: programs an external single timer (clear, load, run),
//   waits for its time-up flag, then steps to the next segment.
// - Plays a host-written table of segments {duration, output code, last}; drives the NMR pulse-sequence gate code.
// - Sits between the DSP register bus (table writes, start/stop) and one single-timer instance on the same clock.
// PARAMETERS
// - DEPTH    16  table entries (power of 2, 2..64); AW = log2(DEPTH)
// - CODE_W   4   width of per-segment output code
// - IDLE_CODE 0  value of seq_code outside a running sequence
// PORTS
// - timeclk      in   1       system/timer clock, all logic on rising edge
// - resetn       in   1       asynchronous active-low reset
// - tbl_we       in   1       table write strobe (one entry per cycle)
// - tbl_addr     in   AW      table write address
// - tbl_wdata    in   17+CODE_W  {last[1], code[CODE_W], dur[16]}
// - start        in   1       one-cycle start pulse
// - stop         in   1       one-cycle abort pulse
// - rep_num      in   8       SEQ_REPEAT_EN only: extra passes of the table (0 = play once)
// - tmr_timeup   in   1       timer time-up flag (sticky until timer cleared)
// - tmr_reset    out  1       timer clear, active high, registered
// - tmr_data     out  16      timer terminal count, registered
// - tmr_work     out  1       timer run enable, active LOW (0 = count), registered
// - seq_code     out  CODE_W  current segment code, registered
// - seq_idx      out  AW      index of current segment
// - busy         out  1       high from accepted start until return to IDLE
// - done         out  1       one-cycle pulse on normal completion (not on stop)
// BEHAVIOUR
// - Reset: state IDLE; tmr_reset=1, tmr_work=1, tmr_data=0, seq_code=IDLE_CODE, seq_idx=0, busy=0, done=0.
// - FSM IDLE -> LOAD -> RUN -> (LOAD | IDLE).
// - IDLE: tmr_reset=1, tmr_work=1. start -> LOAD with idx=0, busy=1. start while busy is ignored.
// - LOAD (1 cycle): tmr_reset=1, tmr_work=1, tmr_data=dur[idx], seq_code=code[idx], seq_idx=idx -> RUN.
// - RUN: tmr_reset=0, tmr_work=0; tmr_timeup ignored in first RUN cycle (clear guard).
//   Timer raises time-up after dur+1 counted edges; on timeup: last=0 -> idx+1, LOAD; last=1 -> end of pass.
// - End of pass: pass count < rep_num (repeat build) -> idx=0, LOAD; else -> IDLE, done=1 for one cycle,
//   seq_code=IDLE_CODE, busy=0.
// - Segment period = dur+3 clocks (LOAD + guard + timeup register); fixed, independent of code/idx.
// - idx wraps DEPTH-1 -> 0 if entry DEPTH-1 lacks last; never stalls on a missing last flag.
// - dur=0: legal, segment lasts 3 clocks. dur=16'hFFFF: legal, no overflow (timer compare is >=).
// - stop: any state -> IDLE next cycle, tmr_reset=1, tmr_work=1, seq_code=IDLE_CODE, no done. stop and start
//   in the same cycle: stop wins. stop coincident with final timeup: stop wins, no done.
// - tbl_we during busy: accepted; an entry takes effect only when next loaded in LOAD.
// - resetn mid-sequence: all outputs to reset values immediately; table contents undefined.
// CONFIGURATION
// - SEQ_REPEAT_EN defined: rep_num honoured, 8-bit pass counter, total passes = rep_num+1; counter cleared on start.
// - SEQ_REPEAT_EN undefined: rep_num port present but ignored; exactly one pass; no pass counter logic.
// STRUCTURE
// - Shared package timer_seq_pkg: state encoding (ST_IDLE/ST_LOAD/ST_RUN), DUR_W=16, entry field offsets
//   (DUR_LSB, CODE_LSB, LAST_BIT), IDLE_CODE default.
// - Sub-module seq_table_ram: DEPTH x (17+CODE_W) one write port, async read (maps to tile RAM or regs).
// - FSM, pass counter and output registers in timer_seq_ctrl; no combinational path from tmr_timeup to outputs.
// TESTING (bench instantiates singletimer on same timeclk/resetn-derived reset)
// - Table {dur=10,code=1},{dur=0,code=2},{dur=5,code=3,last}; start -> seq_code 1 for 13 clks, 2 for 3, 3 for 8;
//   then done pulse, seq_code=0, busy=0.
// - Same table, stop asserted 4 clks into segment 2 -> IDLE next clk, tmr_reset=1, tmr_work=1, no done.
// - SEQ_REPEAT_EN, rep_num=2, one entry {dur=3,code=5,last} -> three 6-clk segments, single done after 18 clks.
// - dur=16'hFFFF single last entry -> seq_code held 65538 clks, then done; no early timeup.
// - start and stop same cycle in IDLE -> stays IDLE, busy=0; start pulse while busy -> idx sequence unchanged.
// - resetn low mid-RUN for 2 clks -> all outputs at reset values during reset; new start after release runs cleanly.

Source files
------------

// File: rtl/timer_seq_pkg.sv
// Shared definitions for the timer sequencer: FSM state encoding and the
// bit layout of a table entry {last, code, dur}.
package timer_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2
   } state_t;

   localparam int DUR_W         = 16;
   localparam int DUR_LSB       = 0;
   localparam int CODE_LSB      = DUR_LSB + DUR_W;
   localparam int IDLE_CODE_DEF = 0;

   // The last flag sits directly above the code field, so its position
   // depends on the code width chosen by the instantiating module.
   function automatic int last_bit(input int code_w);
      return CODE_LSB + code_w;
   endfunction

   function automatic int entry_w(input int code_w);
      return DUR_W + code_w + 1;
   endfunction

endpackage

// File: rtl/seq_table_ram.sv
// Segment table storage: one synchronous write port, one asynchronous read
// port. Contents are not reset; the host reloads the table after reset.
module seq_table_ram #(
   parameter  int DEPTH = 16,
   parameter  int WIDTH = 21,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             timeclk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge timeclk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/timer_seq_ctrl.sv
// Segment sequencer driving an external single-shot timer (clear/load/run)
// and the pulse-sequence gate code. Define SEQ_REPEAT_EN to honour rep_num.
module timer_seq_ctrl
   import timer_seq_pkg::*;
#(
   parameter  int DEPTH     = 16,
   parameter  int CODE_W    = 4,
   parameter  int IDLE_CODE = IDLE_CODE_DEF,
   localparam int AW        = $clog2(DEPTH),
   localparam int EW        = entry_w(CODE_W)
) (
   input  logic              timeclk,
   input  logic              resetn,
   input  logic              tbl_we,
   input  logic [AW-1:0]     tbl_addr,
   input  logic [EW-1:0]     tbl_wdata,
   input  logic              start,
   input  logic              stop,
   input  logic [7:0]        rep_num,
   input  logic              tmr_timeup,
   output logic              tmr_reset,
   output logic [DUR_W-1:0]  tmr_data,
   output logic              tmr_work,
   output logic [CODE_W-1:0] seq_code,
   output logic [AW-1:0]     seq_idx,
   output logic              busy,
   output logic              done
);

   localparam int                LAST_B = last_bit(CODE_W);
   localparam logic [CODE_W-1:0] IDLE_C = CODE_W'(IDLE_CODE);

   state_t            state_reg;
   logic [AW-1:0]     idx_reg;
   logic [AW-1:0]     rd_addr;
   logic [EW-1:0]     rd_data;
   logic              last_reg;
   logic              guard_reg;
   logic              tmr_reset_reg;
   logic              tmr_work_reg;
   logic [DUR_W-1:0]  tmr_data_reg;
   logic [CODE_W-1:0] seq_code_reg;
   logic [AW-1:0]     seq_idx_reg;
   logic              busy_reg;
   logic              done_reg;

   logic              timeup_seen;
   logic              rep_more;
   logic              load_go;
   logic              end_go;

   seq_table_ram #(
      .DEPTH (DEPTH),
      .WIDTH (EW)
   ) u_table (
      .timeclk (timeclk),
      .we      (tbl_we),
      .waddr   (tbl_addr),
      .wdata   (tbl_wdata),
      .raddr   (rd_addr),
      .rdata   (rd_data)
   );

   // The first RUN cycle is the clear guard: the timer has only just left reset.
   assign timeup_seen = (state_reg == ST_RUN) && !guard_reg && tmr_timeup;

`ifdef SEQ_REPEAT_EN
   logic [7:0] pass_cnt_reg;

   assign rep_more = (pass_cnt_reg < rep_num);

   always_ff @(posedge timeclk or negedge resetn) begin
      if (!resetn) begin
         pass_cnt_reg <= '0;
      end else if (state_reg == ST_IDLE && start) begin
         pass_cnt_reg <= '0;
      end else if (timeup_seen && last_reg && rep_more) begin
         pass_cnt_reg <= pass_cnt_reg + 8'd1;
      end
   end
`else
   logic unused_rep;

   assign rep_more   = 1'b0;
   assign unused_rep = &{1'b0, rep_num};
`endif

   // Read address is the index of the segment about to be loaded, so the
   // entry can be registered into the outputs on the edge that enters LOAD.
   always_comb begin
      rd_addr = '0;
      if (state_reg == ST_RUN && !last_reg) begin
         rd_addr = idx_reg + AW'(1);
      end
   end

   assign load_go = !stop && ((state_reg == ST_IDLE && start) ||
                              (timeup_seen && (!last_reg || rep_more)));
   assign end_go  = !stop && timeup_seen && last_reg && !rep_more;

   always_ff @(posedge timeclk or negedge resetn) begin
      if (!resetn) begin
         state_reg     <= ST_IDLE;
         idx_reg       <= '0;
         last_reg      <= 1'b0;
         guard_reg     <= 1'b0;
         tmr_reset_reg <= 1'b1;
         tmr_work_reg  <= 1'b1;
         tmr_data_reg  <= '0;
         seq_code_reg  <= IDLE_C;
         seq_idx_reg   <= '0;
         busy_reg      <= 1'b0;
         done_reg      <= 1'b0;
      end else begin
         done_reg  <= 1'b0;
         guard_reg <= 1'b0;
         if (stop || end_go) begin
            state_reg     <= ST_IDLE;
            idx_reg       <= '0;
            tmr_reset_reg <= 1'b1;
            tmr_work_reg  <= 1'b1;
            seq_code_reg  <= IDLE_C;
            seq_idx_reg   <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= end_go;
         end else if (load_go) begin
            state_reg     <= ST_LOAD;
            idx_reg       <= rd_addr;
            seq_idx_reg   <= rd_addr;
            tmr_data_reg  <= rd_data[DUR_LSB +: DUR_W];
            seq_code_reg  <= rd_data[CODE_LSB +: CODE_W];
            last_reg      <= rd_data[LAST_B];
            tmr_reset_reg <= 1'b1;
            tmr_work_reg  <= 1'b1;
            busy_reg      <= 1'b1;
         end else if (state_reg == ST_LOAD) begin
            state_reg     <= ST_RUN;
            tmr_reset_reg <= 1'b0;
            tmr_work_reg  <= 1'b0;
            guard_reg     <= 1'b1;
         end
      end
   end

   assign tmr_reset = tmr_reset_reg;
   assign tmr_work  = tmr_work_reg;
   assign tmr_data  = tmr_data_reg;
   assign seq_code  = seq_code_reg;
   assign seq_idx   = seq_idx_reg;
   assign busy      = busy_reg;
   assign done      = done_reg;

endmodule
